// File: rtl/ram_pass_check.sv
// ram_pass_check: password stage that follows the ROM user-ID stage.
//
// Collects a 16-bit password as four 4-bit nibbles (MSB first, one per
// enter_button pulse), reads the stored password for the authenticated user
// from a synchronous password RAM and compares the two. A match grants game
// access. MAX_ATTEMPTS consecutive mismatches start a timed lockout of
// LOCK_CYCLES clock cycles.
//
// Optional feature: define PASS_MASTER_KEY_EN to accept MASTER_KEY as an
// override password during the compare. Without it only the RAM decides.
//
// Ports:
//   clock          system clock, rising edge
//   rst            synchronous active-low reset
//   rom_access     user authenticated upstream (level)
//   internal_id    authenticated user index, sampled in the read state
//   toggle_entry   password nibble
//   enter_button   single-cycle strobe for toggle_entry
//   log_out        single-cycle pulse ending the session
//   ram_addr       password RAM read address
//   ram_data       password RAM data, valid the cycle after ram_addr
//   game_access    password accepted
//   green_led_pass mirrors game_access
//   red_led_pass   last compare failed, or locked
//   locked         lockout active
//   attempts_left  remaining attempts before lockout
module ram_pass_check #(
    parameter int unsigned MAX_ATTEMPTS = 3,
    parameter int unsigned LOCK_CYCLES  = 50000000,
    parameter logic [15:0] MASTER_KEY   = 16'hA5C3
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        rom_access,
    input  logic [2:0]  internal_id,
    input  logic [3:0]  toggle_entry,
    input  logic        enter_button,
    input  logic        log_out,
    output logic [2:0]  ram_addr,
    input  logic [15:0] ram_data,
    output logic        game_access,
    output logic        green_led_pass,
    output logic        red_led_pass,
    output logic        locked,
    output logic [1:0]  attempts_left
);

    localparam logic [1:0]  MaxAtt   = 2'(MAX_ATTEMPTS);
    localparam logic [25:0] LockLoad = 26'(LOCK_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StCollect,
        StRead,
        StWait,
        StCompare,
        StGrant,
        StLock
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] pw_q, pw_d;
    logic [1:0]  nib_q, nib_d;
    logic [25:0] lock_cnt_q, lock_cnt_d;
    logic [2:0]  ram_addr_q, ram_addr_d;
    logic        game_q, game_d;
    logic        green_q, green_d;
    logic        red_q, red_d;
    logic        locked_q, locked_d;
    logic [1:0]  att_q, att_d;

    logic pw_match;
    logic session_abort;

`ifdef PASS_MASTER_KEY_EN
    assign pw_match = (pw_q == ram_data) || (pw_q == MASTER_KEY);
`else
    assign pw_match = (pw_q == ram_data);
    logic unused_master_key;
    assign unused_master_key = ^MASTER_KEY;
`endif

    // Leaving the session keeps attempts_left so logging out cannot refill it.
    assign session_abort = log_out || !rom_access;

    always_ff @(posedge clock) begin
        if (!rst) begin
            state_q    <= StIdle;
            pw_q       <= '0;
            nib_q      <= '0;
            lock_cnt_q <= '0;
            ram_addr_q <= '0;
            game_q     <= 1'b0;
            green_q    <= 1'b0;
            red_q      <= 1'b0;
            locked_q   <= 1'b0;
            att_q      <= MaxAtt;
        end else begin
            state_q    <= state_d;
            pw_q       <= pw_d;
            nib_q      <= nib_d;
            lock_cnt_q <= lock_cnt_d;
            ram_addr_q <= ram_addr_d;
            game_q     <= game_d;
            green_q    <= green_d;
            red_q      <= red_d;
            locked_q   <= locked_d;
            att_q      <= att_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pw_d       = pw_q;
        nib_d      = nib_q;
        lock_cnt_d = lock_cnt_q;
        ram_addr_d = ram_addr_q;
        game_d     = game_q;
        red_d      = red_q;
        locked_d   = locked_q;
        att_d      = att_q;

        unique case (state_q)
            StIdle: begin
                if (log_out) begin
                    pw_d  = '0;
                    nib_d = '0;
                end else if (rom_access) begin
                    state_d = StCollect;
                end
            end

            StCollect: begin
                if (session_abort) begin
                    state_d = StIdle;
                    pw_d    = '0;
                    nib_d   = '0;
                end else if (enter_button) begin
                    pw_d = {pw_q[11:0], toggle_entry};
                    if (nib_q == 2'd0) begin
                        red_d = 1'b0;
                    end
                    if (nib_q == 2'd3) begin
                        nib_d   = '0;
                        state_d = StRead;
                    end else begin
                        nib_d = nib_q + 2'd1;
                    end
                end
            end

            StRead: begin
                if (session_abort) begin
                    state_d = StIdle;
                    pw_d    = '0;
                end else begin
                    ram_addr_d = internal_id;
                    state_d    = StWait;
                end
            end

            // RAM read latency.
            StWait: begin
                if (session_abort) begin
                    state_d = StIdle;
                    pw_d    = '0;
                end else begin
                    state_d = StCompare;
                end
            end

            StCompare: begin
                if (session_abort) begin
                    state_d = StIdle;
                    pw_d    = '0;
                end else if (pw_match) begin
                    state_d = StGrant;
                    game_d  = 1'b1;
                    att_d   = MaxAtt;
                end else begin
                    att_d = att_q - 2'd1;
                    red_d = 1'b1;
                    pw_d  = '0;
                    if (att_q == 2'd1) begin
                        state_d    = StLock;
                        locked_d   = 1'b1;
                        lock_cnt_d = LockLoad;
                    end else begin
                        state_d = StCollect;
                    end
                end
            end

            StGrant: begin
                if (session_abort) begin
                    state_d = StIdle;
                    game_d  = 1'b0;
                    pw_d    = '0;
                end
            end

            // All user inputs are ignored until the counter expires.
            StLock: begin
                if (lock_cnt_q == '0) begin
                    state_d  = StIdle;
                    locked_d = 1'b0;
                    red_d    = 1'b0;
                    att_d    = MaxAtt;
                end else begin
                    lock_cnt_d = lock_cnt_q - 26'd1;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        green_d = game_d;
    end

    assign ram_addr       = ram_addr_q;
    assign game_access    = game_q;
    assign green_led_pass = green_q;
    assign red_led_pass   = red_q;
    assign locked         = locked_q;
    assign attempts_left  = att_q;

endmodule

// File: tb/tb_ram_pass_check.sv
module tb_ram_pass_check;

    localparam int LockCycles = 10;
    localparam int MaxAtt     = 3;

    logic        clock = 1'b0;
    logic        rst;
    logic        rom_access;
    logic [2:0]  internal_id;
    logic [3:0]  toggle_entry;
    logic        enter_button;
    logic        log_out;
    logic [2:0]  ram_addr;
    logic [15:0] ram_data;
    logic        game_access;
    logic        green_led_pass;
    logic        red_led_pass;
    logic        locked;
    logic [1:0]  attempts_left;

    logic [15:0] mem [8];

    int checks = 0;
    int errors = 0;

    ram_pass_check #(
        .MAX_ATTEMPTS(MaxAtt),
        .LOCK_CYCLES (LockCycles),
        .MASTER_KEY  (16'hA5C3)
    ) dut (
        .clock         (clock),
        .rst           (rst),
        .rom_access    (rom_access),
        .internal_id   (internal_id),
        .toggle_entry  (toggle_entry),
        .enter_button  (enter_button),
        .log_out       (log_out),
        .ram_addr      (ram_addr),
        .ram_data      (ram_data),
        .game_access   (game_access),
        .green_led_pass(green_led_pass),
        .red_led_pass  (red_led_pass),
        .locked        (locked),
        .attempts_left (attempts_left)
    );

    always #5 clock = ~clock;

    // Synchronous-read password RAM.
    always @(posedge clock) ram_data <= mem[ram_addr];

    typedef struct {
        logic       ra;
        logic [2:0] id;
        logic [3:0] tog;
        logic       en;
        logic       lo;
        logic       eg;
        logic       er;
        logic       el;
        logic [1:0] ea;
        logic [2:0] eaddr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic ra, logic [2:0] id, logic [3:0] tog, logic en, logic lo,
                                logic eg, logic er, logic el, logic [1:0] ea, logic [2:0] eaddr);
        vec_t v;
        v.ra = ra; v.id = id; v.tog = tog; v.en = en; v.lo = lo;
        v.eg = eg; v.er = er; v.el = el; v.ea = ea; v.eaddr = eaddr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic expect_outs(input string tag, input logic eg, input logic er, input logic el,
                               input logic [1:0] ea);
        check({tag, ".game"}, 32'(game_access), 32'(eg));
        check({tag, ".green"}, 32'(green_led_pass), 32'(eg));
        check({tag, ".red"}, 32'(red_led_pass), 32'(er));
        check({tag, ".locked"}, 32'(locked), 32'(el));
        check({tag, ".att"}, 32'(attempts_left), 32'(ea));
    endtask

    // Apply inputs just after a falling edge; return at the next falling edge
    // so outputs reflect the rising edge that sampled those inputs.
    task automatic drive(input logic ra, input logic [2:0] id, input logic [3:0] t,
                         input logic en, input logic lo);
        rom_access   = ra;
        internal_id  = id;
        toggle_entry = t;
        enter_button = en;
        log_out      = lo;
        @(negedge clock);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive(1'b0, 3'd0, 4'h0, 1'b0, 1'b0);
        drive(1'b0, 3'd0, 4'h0, 1'b0, 1'b0);
        rst = 1'b1;
    endtask

    // Enter four nibbles MSB first; returns when the compare result is visible.
    task automatic enter_pw(input logic [2:0] id, input logic [15:0] pw, input int max_gap);
        int g;
        for (int i = 3; i >= 0; i--) begin
            g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            for (int j = 0; j < g; j++) drive(1'b1, id, 4'h0, 1'b0, 1'b0);
            drive(1'b1, id, pw[i*4 +: 4], 1'b1, 1'b0);
        end
        for (int j = 0; j < 3; j++) drive(1'b1, id, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic lock_out(input logic [2:0] id);
        for (int k = 0; k < MaxAtt; k++) begin
            drive(1'b1, id, 4'h0, 1'b0, 1'b0);
            enter_pw(id, mem[id] ^ 16'h0101, 0);
        end
    endtask

    function automatic logic model_match(logic [15:0] pw, logic [15:0] stored);
`ifdef PASS_MASTER_KEY_EN
        return (pw == stored) || (pw == 16'hA5C3);
`else
        return pw == stored;
`endif
    endfunction

    initial begin
        int          att_m;
        int          act;
        int          k;
        logic [2:0]  id;
        logic [15:0] pw;
        logic        m;

        for (int i = 0; i < 8; i++) mem[i] = 16'($urandom);
        mem[5] = 16'h1234;
        mem[2] = 16'h1230;

        rst = 1'b0;
        rom_access = 1'b0; internal_id = '0; toggle_entry = '0;
        enter_button = 1'b0; log_out = 1'b0;
        @(negedge clock);

        // Reset state
        do_reset();
        expect_outs("reset", 1'b0, 1'b0, 1'b0, 2'd3);
        check("reset.addr", 32'(ram_addr), 32'd0);

        // Table: grant, GRANT hold, log_out, two wrong entries, then correct entry.
        tbl.push_back(mk(1, 5, 4'h0, 0, 0, 0, 0, 0, 3, 0));
        for (int i = 1; i <= 4; i++) tbl.push_back(mk(1, 5, 4'(i), 1, 0, 0, 0, 0, 3, 0));
        tbl.push_back(mk(1, 5, 4'h0, 0, 0, 0, 0, 0, 3, 5));
        tbl.push_back(mk(1, 5, 4'h0, 0, 0, 0, 0, 0, 3, 5));
        tbl.push_back(mk(1, 5, 4'h0, 0, 0, 1, 0, 0, 3, 5));
        tbl.push_back(mk(1, 5, 4'hF, 1, 0, 1, 0, 0, 3, 5));
        tbl.push_back(mk(1, 5, 4'h0, 0, 1, 0, 0, 0, 3, 5));
        tbl.push_back(mk(1, 5, 4'h0, 0, 0, 0, 0, 0, 3, 5));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 5, 4'h0, 1, 0, 0, 0, 0, 3, 5));
        tbl.push_back(mk(1, 5, 4'h0, 0, 0, 0, 0, 0, 3, 5));
        tbl.push_back(mk(1, 5, 4'h0, 0, 0, 0, 0, 0, 3, 5));
        tbl.push_back(mk(1, 5, 4'h0, 0, 0, 0, 1, 0, 2, 5));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 5, 4'h0, 1, 0, 0, 0, 0, 2, 5));
        tbl.push_back(mk(1, 5, 4'h0, 0, 0, 0, 0, 0, 2, 5));
        tbl.push_back(mk(1, 5, 4'h0, 0, 0, 0, 0, 0, 2, 5));
        tbl.push_back(mk(1, 5, 4'h0, 0, 0, 0, 1, 0, 1, 5));
        tbl.push_back(mk(1, 5, 4'h0, 0, 0, 0, 1, 0, 1, 5));
        for (int i = 1; i <= 4; i++) tbl.push_back(mk(1, 5, 4'(i), 1, 0, 0, 0, 0, 1, 5));
        tbl.push_back(mk(1, 5, 4'h0, 0, 0, 0, 0, 0, 1, 5));
        tbl.push_back(mk(1, 5, 4'h0, 0, 0, 0, 0, 0, 1, 5));
        tbl.push_back(mk(1, 5, 4'h0, 0, 0, 1, 0, 0, 3, 5));
        tbl.push_back(mk(0, 5, 4'h0, 0, 0, 0, 0, 0, 3, 5));
        tbl.push_back(mk(0, 5, 4'h0, 0, 0, 0, 0, 0, 3, 5));

        foreach (tbl[i]) begin
            drive(tbl[i].ra, tbl[i].id, tbl[i].tog, tbl[i].en, tbl[i].lo);
            expect_outs($sformatf("tbl%0d", i), tbl[i].eg, tbl[i].er, tbl[i].el, tbl[i].ea);
            check($sformatf("tbl%0d.addr", i), 32'(ram_addr), 32'(tbl[i].eaddr));
        end

        // Lockout: locked for exactly LockCycles cycles, user inputs ignored.
        lock_out(3'd5);
        expect_outs("lock.start", 1'b0, 1'b1, 1'b1, 2'd0);
        for (int c = 1; c < LockCycles; c++) begin
            drive(1'b1, 3'd5, 4'h1, c[0], ~c[0]);
            expect_outs($sformatf("lock.c%0d", c), 1'b0, 1'b1, 1'b1, 2'd0);
        end
        drive(1'b1, 3'd5, 4'h0, 1'b0, 1'b0);
        expect_outs("lock.end", 1'b0, 1'b0, 1'b0, 2'd3);

        // Partial entry then log_out is discarded.
        drive(1'b1, 3'd5, 4'h0, 1'b0, 1'b0);
        drive(1'b1, 3'd5, 4'hA, 1'b1, 1'b0);
        drive(1'b1, 3'd5, 4'hB, 1'b1, 1'b0);
        drive(1'b1, 3'd5, 4'h0, 1'b0, 1'b1);
        expect_outs("partial.out", 1'b0, 1'b0, 1'b0, 2'd3);
        drive(1'b1, 3'd5, 4'h0, 1'b0, 1'b0);
        enter_pw(3'd5, 16'h1234, 0);
        expect_outs("partial.regrant", 1'b1, 1'b0, 1'b0, 2'd3);
        drive(1'b1, 3'd5, 4'h0, 1'b0, 1'b1);
        expect_outs("grant.logout", 1'b0, 1'b0, 1'b0, 2'd3);

        // Same-cycle log_out and enter_button: the nibble must not count.
        drive(1'b1, 3'd5, 4'h0, 1'b0, 1'b0);
        drive(1'b1, 3'd5, 4'hF, 1'b1, 1'b1);
        drive(1'b1, 3'd5, 4'h0, 1'b0, 1'b0);
        enter_pw(3'd5, 16'h1234, 0);
        expect_outs("logout_prio", 1'b1, 1'b0, 1'b0, 2'd3);
        drive(1'b1, 3'd5, 4'h0, 1'b0, 1'b1);

        // Master key against RAM value 16'h1234.
        drive(1'b1, 3'd5, 4'h0, 1'b0, 1'b0);
        enter_pw(3'd5, 16'hA5C3, 0);
`ifdef PASS_MASTER_KEY_EN
        expect_outs("master", 1'b1, 1'b0, 1'b0, 2'd3);
`else
        expect_outs("master", 1'b0, 1'b1, 1'b0, 2'd2);
`endif

        // Reset held in the middle of a lockout.
        do_reset();
        lock_out(3'd2);
        drive(1'b1, 3'd2, 4'h0, 1'b0, 1'b0);
        drive(1'b1, 3'd2, 4'h0, 1'b0, 1'b0);
        check("midlock.locked", 32'(locked), 32'd1);
        rst = 1'b0;
        drive(1'b1, 3'd2, 4'h3, 1'b1, 1'b0);
        expect_outs("midlock.rst", 1'b0, 1'b0, 1'b0, 2'd3);
        check("midlock.addr", 32'(ram_addr), 32'd0);
        rst = 1'b1;

        // Randomized sessions against a transaction-level model.
        do_reset();
        for (int i = 0; i < 8; i++) mem[i] = 16'($urandom);
        att_m = MaxAtt;
        for (int it = 0; it < 40; it++) begin
            id  = 3'($urandom_range(0, 7));
            act = int'($urandom_range(0, 3));
            drive(1'b1, id, 4'h0, 1'b0, 1'b0);
            if (act == 3) begin
                k = int'($urandom_range(1, 3));
                for (int n = 0; n < k; n++) drive(1'b1, id, 4'($urandom), 1'b1, 1'b0);
                drive(1'b1, id, 4'h0, 1'b0, 1'b1);
                check($sformatf("rnd%0d.part.game", it), 32'(game_access), 32'd0);
                check($sformatf("rnd%0d.part.att", it), 32'(attempts_left), 32'(att_m));
                check($sformatf("rnd%0d.part.locked", it), 32'(locked), 32'd0);
            end else begin
                pw = (act == 0) ? mem[id] : mem[id] ^ 16'($urandom_range(1, 65535));
                m  = model_match(pw, mem[id]);
                enter_pw(id, pw, 2);
                check($sformatf("rnd%0d.addr", it), 32'(ram_addr), 32'(id));
                if (m) begin
                    att_m = MaxAtt;
                    expect_outs($sformatf("rnd%0d.ok", it), 1'b1, 1'b0, 1'b0, 2'(att_m));
                    drive(1'b1, id, 4'h0, 1'b0, 1'b1);
                    check($sformatf("rnd%0d.logout", it), 32'(game_access), 32'd0);
                end else begin
                    att_m--;
                    expect_outs($sformatf("rnd%0d.bad", it), 1'b0, 1'b1, att_m == 0, 2'(att_m));
                    if (att_m == 0) begin
                        for (int c = 1; c < LockCycles; c++) begin
                            drive(1'b1, id, 4'($urandom), 1'($urandom), 1'($urandom));
                            check($sformatf("rnd%0d.lock%0d", it, c), 32'(locked), 32'd1);
                        end
                        drive(1'b1, id, 4'h0, 1'b0, 1'b0);
                        att_m = MaxAtt;
                        expect_outs($sformatf("rnd%0d.unlock", it), 1'b0, 1'b0, 1'b0, 2'(att_m));
                    end
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_pass_check.md
Name: ram_pass_check

Overview:
- Stage directly downstream of the ROM user-ID stage. It is enabled once that stage asserts ROM access and presents the 3-bit internal user ID.
- Collects a 16-bit password as four 4-bit toggle entries, reads the stored password for that user from the password RAM (1-cycle synchronous read), and compares the two.
- On match it grants game access. On mismatch it counts failed attempts and enforces a timed lockout after MAX_ATTEMPTS failures.

Parameters:
- MAX_ATTEMPTS, 3, failed compares allowed before lockout; legal range 1..3.
- LOCK_CYCLES, 50000000, lockout duration in clock cycles; legal range 1..2^26-1.
- MASTER_KEY, 16'hA5C3, override password; used only when the optional feature is compiled in.

Ports:
- clock  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-low reset.
- rom_access  in  1  user ID authenticated upstream; level.
- internal_id  in  3  authenticated user index; sampled in READ.
- toggle_entry  in  4  password nibble.
- enter_button  in  1  single-cycle pulse (debounced upstream); strobes toggle_entry.
- log_out  in  1  single-cycle pulse; ends the session.
- ram_addr  out  3  password RAM read address.
- ram_data  in  16  password RAM read data; valid the cycle after ram_addr is driven.
- game_access  out  1  password accepted.
- green_led_pass  out  1  mirrors game_access.
- red_led_pass  out  1  last compare failed, or block is locked.
- locked  out  1  lockout active.
- attempts_left  out  2  remaining attempts.

Behaviour:
- Reset (rst=0 at a clock edge):
  - state=IDLE; password register and nibble count cleared; lock counter cleared.
  - ram_addr=0, game_access=0, green_led_pass=0, red_led_pass=0, locked=0, attempts_left=MAX_ATTEMPTS.
  - Reset overrides every other input in every state, including LOCK.
- All outputs are registered.
- IDLE:
  - Moves to COLLECT when rom_access=1.
  - Ignores enter_button.
- COLLECT:
  - Each enter_button pulse shifts the entry in MSB-first: pw <= {pw[11:0], toggle_entry}; nibble count +1.
  - The first nibble of a new entry clears red_led_pass.
  - On the 4th nibble: nibble count returns to 0 and state goes to READ on the next cycle.
- READ (1 cycle): ram_addr <= internal_id. Next state WAIT.
- WAIT (1 cycle): RAM latency. Next state COMPARE.
- COMPARE (1 cycle):
  - pw==ram_data: go to GRANT; game_access=1; attempts_left=MAX_ATTEMPTS.
  - pw!=ram_data: attempts_left decrements and red_led_pass=1.
    - Result 0: go to LOCK; lock counter loaded with LOCK_CYCLES-1; locked=1.
    - Otherwise: back to COLLECT with pw cleared.
- Latency: the 4th enter_button pulse is followed by game_access or red_led_pass high exactly 4 cycles later.
- GRANT:
  - Holds game_access=1.
  - Ignores enter_button.
  - Exits to IDLE on log_out, or on rom_access=0; game_access drops the next cycle.
- LOCK:
  - Counter decrements each cycle; enter_button, log_out and rom_access are all ignored.
  - When the counter reaches 0: locked=0, red_led_pass=0, attempts_left=MAX_ATTEMPTS, state=IDLE.
- log_out in IDLE, COLLECT, READ, WAIT or COMPARE:
  - Goes to IDLE; pw and nibble count cleared.
  - attempts_left is preserved, so log_out cannot be used to reset the attempt count.
  - log_out has priority over a same-cycle enter_button.
- rom_access=0 in COLLECT, READ, WAIT or COMPARE: go to IDLE, pw cleared, attempts_left preserved.
- log_out and a compare result in the same cycle: log_out wins; no grant, no decrement.
- A partial entry (fewer than 4 nibbles) is never compared.

Optional Feature:
- Macro: PASS_MASTER_KEY_EN.
- Defined: in COMPARE, pw==MASTER_KEY grants access regardless of ram_data, with attempts_left restored to MAX_ATTEMPTS. The key is not accepted in LOCK, because entries are not collected there.
- Undefined: MASTER_KEY is unused and only the RAM comparison decides.

Test Plan:
- Reset, then rom_access=1, internal_id=5, nibbles 1,2,3,4, RAM[5]=16'h1234 -> ram_addr=5 two cycles after the 4th pulse; game_access=1 and green_led_pass=1 four cycles after it; attempts_left=3.
- Wrong entry 16'h0000 vs RAM 16'h1234, twice -> red_led_pass=1 and attempts_left 2 then 1; state returns to COLLECT; game_access stays 0.
- Three wrong entries with LOCK_CYCLES=10 -> locked=1 and attempts_left=0 for exactly 10 cycles; log_out and enter_button pulses are ignored; then locked=0 and attempts_left=3.
- Two nibbles entered, then log_out -> IDLE; re-entry 1,2,3,4 grants access (the partial entry is discarded); log_out in GRANT -> game_access=0 the next cycle.
- Same-cycle log_out and enter_button in COLLECT -> IDLE with nibble count 0. rst=0 held mid-LOCK -> all outputs reach reset values at the next edge.
- With PASS_MASTER_KEY_EN defined: entry 16'hA5C3 with RAM holding 16'h1234 -> game_access=1. With the macro undefined, the same stimulus -> red_led_pass=1.
